// File: rtl/divider_unit.sv
// divider_unit: iterative non-restoring integer divider, signed or unsigned.
// Companion of the carry-save multiplier inside the multiply/division unit.
// Optional build macro: DIVIDER_EARLY_OUT_EN. When defined, LOAD finishes
// divide-by-zero and unsigned dividend<divisor cases directly. Results are
// the same in both builds; only the latency changes.
//
// Handshake outputs (done, busy, quotient, remainder, div_by_zero) are
// registered one stage after the FSM. The visible done pulse therefore
// lands in the cycle after the DONE state. start is refused while that
// pulse is high, so a start presented in the done cycle is dropped.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; operands captured when it is accepted
// LOAD    | form magnitudes and result signs, clear partial remainder
// ITER    | one non-restoring step per cycle, parallelism cycles
// CORRECT | final remainder restore, sign fix-up, divide-by-zero override
// DONE    | results staged; the visible outputs update on leaving
module divider_unit #(
  parameter int parallelism = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   usigned,
  input  logic [parallelism-1:0] dividend,
  input  logic [parallelism-1:0] divisor,
  output logic                   busy,
  output logic                   done,
  output logic [parallelism-1:0] quotient,
  output logic [parallelism-1:0] remainder,
  output logic                   div_by_zero
);

  localparam int W  = parallelism;
  localparam int CW = $clog2(parallelism);
  localparam logic [CW-1:0] LAST = CW'(parallelism - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    CORRECT,
    DONE
  } state_t;

  state_t state, state_nxt;

  // captured operands
  logic [W-1:0]  op_a, op_b;
  logic          op_u;

  // iteration datapath: partial remainder is one bit wider and signed
  logic [W:0]    rem_r;
  logic [W-1:0]  quo_r;
  logic [W:0]    div_mag;
  logic          q_neg, r_neg;
  logic [CW-1:0] cnt;

  // final results, staged until the done pulse
  logic [W-1:0]  res_q, res_r;
  logic          res_z;

  // combinational helpers
  logic          accept;
  logic          a_neg, b_neg, div_zero;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    r_sh, r_nxt, r_fix;
  logic [W-1:0]  q_nxt, q_fin, r_low, r_fin;
`ifdef DIVIDER_EARLY_OUT_EN
  logic          early_out;
`endif

  assign accept = (state == IDLE) && start && !done;

  // operand magnitudes, one non-restoring step, and the final fix-up
  always_comb begin
    a_neg    = ~op_u & op_a[W-1];
    b_neg    = ~op_u & op_b[W-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = (op_b == '0);
    // The add/subtract choice uses the sign before the shift. After the
    // shift the top bit can wrap when the divisor is close to 2^W, but the
    // result of the step always fits again in W+1 bits.
    r_sh     = {rem_r[W-1:0], quo_r[W-1]};
    r_nxt    = rem_r[W] ? (r_sh + div_mag) : (r_sh - div_mag);
    q_nxt    = {quo_r[W-2:0], ~r_nxt[W]};
    r_fix    = rem_r[W] ? (rem_r + div_mag) : rem_r;
    r_low    = r_fix[W-1:0];
    q_fin    = q_neg ? -quo_r : quo_r;
    r_fin    = r_neg ? -r_low : r_low;
  end

`ifdef DIVIDER_EARLY_OUT_EN
  // trivially known results: divide by zero, or unsigned dividend < divisor
  always_comb begin
    early_out = div_zero | (op_u & (op_a < op_b));
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
`ifdef DIVIDER_EARLY_OUT_EN
      LOAD:    state_nxt = early_out ? DONE : ITER;
`else
      LOAD:    state_nxt = ITER;
`endif
      ITER:    if (cnt == LAST) state_nxt = CORRECT;
      CORRECT: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, iteration datapath and result staging
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_u    <= 1'b0;
      rem_r   <= '0;
      quo_r   <= '0;
      div_mag <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      res_r   <= '0;
      res_z   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a <= dividend;
            op_b <= divisor;
            op_u <= usigned;
          end
        end
        LOAD: begin
          div_mag <= {1'b0, b_mag};
          quo_r   <= a_mag;
          rem_r   <= '0;
          cnt     <= '0;
          q_neg   <= a_neg ^ b_neg;
          r_neg   <= a_neg;
`ifdef DIVIDER_EARLY_OUT_EN
          if (div_zero) begin
            res_q <= '1;
            res_r <= op_a;
            res_z <= 1'b1;
          end else if (early_out) begin
            res_q <= '0;
            res_r <= op_a;
            res_z <= 1'b0;
          end
`endif
        end
        ITER: begin
          rem_r <= r_nxt;
          quo_r <= q_nxt;
          cnt   <= cnt + CW'(1);
        end
        CORRECT: begin
          // The overflow case MIN / -1 needs no special handling: the
          // magnitude quotient 2^(W-1) already reads back as MIN.
          if (div_zero) begin
            res_q <= '1;
            res_r <= op_a;
            res_z <= 1'b1;
          end else begin
            res_q <= q_fin;
            res_r <= r_fin;
            res_z <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE) || (state == DONE);
      done <= (state == DONE);
      if (state == DONE) begin
        quotient    <= res_q;
        remainder   <= res_r;
        div_by_zero <= res_z;
      end
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: directed vectors with hand-computed results for
// divider_unit at parallelism=32, plus handshake and mid-operation reset.
module tb_divider_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        usigned = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_errors = 0;

  divider_unit #(.parallelism(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .usigned    (usigned),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // called #1 after the accepting edge; counts edges until done is seen
  task automatic wait_done(output int cyc, output logic busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic u, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq,
                       input logic [31:0] er, input logic ez);
    int   cyc;
    int   exp_lat;
    logic busy_ok;
    exp_lat = 35;
`ifdef DIVIDER_EARLY_OUT_EN
    if (b == 32'd0 || (u && a < b)) exp_lat = 2;
`endif
    @(negedge clk);
    usigned = u; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, busy_ok);
    check_val({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_val({tag, "_busy_during"}, {31'b0, busy_ok}, 32'd1);
    check_val({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
    check_val({tag, "_quotient"}, quotient, eq);
    check_val({tag, "_remainder"}, remainder, er);
    check_val({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check_val({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int   cyc;
    logic busy_ok;
    logic saw_done;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_quotient", quotient, 32'd0);
    check_val("rst_remainder", remainder, 32'd0);
    check_val("rst_dbz", {31'b0, div_by_zero}, 32'd0);

    //     tag             u     dividend      divisor       quotient      remainder     dbz
    do_op("u_100_7",      1'b1, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
    do_op("s_m100_7",     1'b0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    do_op("s_100_m7",     1'b0, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0);
    do_op("s_m100_m7",    1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0);
    do_op("s_m5_0",       1'b0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
    do_op("u_5_0",        1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1);
    do_op("s_ovf",        1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
    do_op("u_max_1",      1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0);
    do_op("u_max_max",    1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0);
    do_op("u_small",      1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 1'b0);
    do_op("u_3_10",       1'b1, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0);
    do_op("u_min_3",      1'b1, 32'h80000000, 32'd3,        32'h2AAAAAAA, 32'd2,        1'b0);
    do_op("s_7_m100",     1'b0, 32'd7,        32'hFFFFFF9C, 32'd0,        32'd7,        1'b0);
    do_op("s_m7_2",       1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);

    // handshake: starts while busy and in the done cycle are dropped
    @(negedge clk);
    usigned = 1'b1; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, busy_ok);
    check_val("hs_latency", 32'(cyc), 32'd30);
    check_val("hs_busy_during", {31'b0, busy_ok}, 32'd1);
    check_val("hs_quotient", quotient, 32'd14);
    check_val("hs_remainder", remainder, 32'd2);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("hs_done_start_busy", {31'b0, busy}, 32'd0);
    check_val("hs_done_start_done", {31'b0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("hs_idle_busy", {31'b0, busy}, 32'd0);
    check_val("hs_hold_quotient", quotient, 32'd14);
    do_op("hs_next",      1'b1, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0);

    // reset during iteration 10 aborts with no done pulse
    @(negedge clk);
    usigned = 1'b1; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_val("mid_rst_done", {31'b0, done}, 32'd0);
    check_val("mid_rst_quotient", quotient, 32'd0);
    check_val("mid_rst_remainder", remainder, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check_val("mid_rst_no_done", {31'b0, saw_done}, 32'd0);
    do_op("after_rst",    1'b1, 32'd50,       32'd5,        32'd10,       32'd0,        1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
